// File: rtl/pool_ctrl_pkg.sv
// Shared types and defaults for the pooling task controller.
package pool_ctrl_pkg;

    localparam int unsigned HEIGHT_W_DEF  = 9;
    localparam int unsigned ADDRSEL_W_DEF = 3;

    localparam logic POOL_MOD_MAX = 1'b0;
    localparam logic POOL_MOD_AVG = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StAck
    } pool_state_e;

endpackage

// File: rtl/pool_row_watchdog.sv
// Per-row watchdog: counts cycles while run is high and flags expiry at TIMEOUT_CYC-1.
module pool_row_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/pool_task_ctrl.sv
// Pooling task sequencer: accepts PoolReq, issues one RowStart per output row, returns PoolAck.
// Optional per-row timeout is enabled by defining POOL_TIMEOUT_EN.
module pool_task_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int unsigned HEIGHT_W  = HEIGHT_W_DEF,
    parameter int unsigned ADDRSEL_W = ADDRSEL_W_DEF
`ifdef POOL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 PoolReq_i,
    input  logic [HEIGHT_W-1:0]  PoolHeight_i,
    input  logic                 PoolMod_i,
    input  logic [ADDRSEL_W-1:0] PoolAddrSel_i,
    output logic                 PoolAck_o,
    output logic                 Busy_o,
    output logic                 RowStart_o,
    output logic [HEIGHT_W-1:0]  SrcRow_o,
    output logic [HEIGHT_W-1:0]  DstRow_o,
    output logic                 RowMod_o,
    output logic [ADDRSEL_W-1:0] RowAddrSel_o,
    input  logic                 RowDone_i,
    output logic [7:0]           ReqDropCnt_o,
    output logic                 Err_o
);

    localparam int unsigned RW = HEIGHT_W - 1;

    pool_state_e          state_q, state_d;
    logic [RW-1:0]        num_rows_q, dst_row_q;
    logic                 mod_q;
    logic [ADDRSEL_W-1:0] addrsel_q;
    logic [7:0]           drop_cnt_q;
    logic                 last_row;
    logic                 timeout;
    logic                 accept;

    assign accept   = (state_q == StIdle) && PoolReq_i;
    assign last_row = (dst_row_q == num_rows_q - RW'(1));

`ifdef POOL_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    pool_row_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (state_q == StLaunch),
        .run    (state_q == StWait),
        .expired(wd_expired)
    );

    // A done arriving in the expiry cycle wins over the timeout.
    assign timeout = wd_expired && !RowDone_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if ((state_q == StWait) && timeout) begin
            err_q <= 1'b1;
        end
    end

    assign Err_o = err_q;
`else
    assign timeout = 1'b0;
    assign Err_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (PoolReq_i) begin
                    state_d = (PoolHeight_i[HEIGHT_W-1:1] == '0) ? StAck : StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (RowDone_i) begin
                    state_d = last_row ? StAck : StLaunch;
                end else if (timeout) begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        RowStart_o = 1'b0;
        PoolAck_o  = 1'b0;
        Busy_o     = 1'b1;
        unique case (state_q)
            StIdle:   Busy_o = 1'b0;
            StLaunch: RowStart_o = 1'b1;
            StWait:   ;
            StAck:    PoolAck_o = 1'b1;
            default:  Busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_rows_q <= '0;
            dst_row_q  <= '0;
            mod_q      <= 1'b0;
            addrsel_q  <= '0;
        end else if (accept) begin
            num_rows_q <= PoolHeight_i[HEIGHT_W-1:1];
            dst_row_q  <= '0;
            mod_q      <= PoolMod_i;
            addrsel_q  <= PoolAddrSel_i;
        end else if ((state_q == StWait) && RowDone_i && !last_row) begin
            dst_row_q <= dst_row_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
        end else if (PoolReq_i && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign SrcRow_o     = {dst_row_q, 1'b0};
    assign DstRow_o     = {1'b0, dst_row_q};
    assign RowMod_o     = mod_q;
    assign RowAddrSel_o = addrsel_q;
    assign ReqDropCnt_o = drop_cnt_q;

endmodule

// File: tb/tb_pool_task_ctrl.sv
// Randomized bench for pool_task_ctrl, acting as the pool datapath and checking row sequencing.
module tb_pool_task_ctrl;
    import pool_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pool_req = 1'b0;
    logic [8:0] pool_height = '0;
    logic       pool_mod = 1'b0;
    logic [2:0] pool_addrsel = '0;
    logic       row_done = 1'b0;
    logic       pool_ack, busy, row_start, row_mod, err;
    logic [8:0] src_row, dst_row;
    logic [2:0] row_addrsel;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int drop_model = 0;

    always #5 clk = ~clk;

    pool_task_ctrl #(
        .HEIGHT_W (9),
        .ADDRSEL_W(3)
`ifdef POOL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .PoolReq_i    (pool_req),
        .PoolHeight_i (pool_height),
        .PoolMod_i    (pool_mod),
        .PoolAddrSel_i(pool_addrsel),
        .PoolAck_o    (pool_ack),
        .Busy_o       (busy),
        .RowStart_o   (row_start),
        .SrcRow_o     (src_row),
        .DstRow_o     (dst_row),
        .RowMod_o     (row_mod),
        .RowAddrSel_o (row_addrsel),
        .RowDone_i    (row_done),
        .ReqDropCnt_o (drop_cnt),
        .Err_o        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_drops();
        return (drop_model > 255) ? 255 : drop_model;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, pool_ack, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_start"}, row_start, 0);
        check_eq({tag, "_src"}, src_row, 0);
        check_eq({tag, "_dst"}, dst_row, 0);
        check_eq({tag, "_mod"}, row_mod, 0);
        check_eq({tag, "_asel"}, row_addrsel, 0);
        check_eq({tag, "_drops"}, drop_cnt, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    // One complete task as seen from the datapath side; abort_row >= 0 resets mid-WAIT.
    task automatic run_task(input int height, input logic mod, input logic [2:0] asel,
                            input bit drop_wait, input bit drop_ack, input bit launch_done,
                            input int abort_row);
        int nrows;
        int d;
        nrows = height / 2;
        check_eq("idle_before_req", busy, 0);
        pool_req = 1'b1;
        pool_height = 9'(height);
        pool_mod = mod;
        pool_addrsel = asel;
        step();
        pool_req = 1'b0;
        pool_height = 9'($urandom);
        pool_mod = ~mod;
        pool_addrsel = ~asel;
        if (nrows == 0) begin
            check_eq("empty_start", row_start, 0);
        end
        for (int r = 0; r < nrows; r++) begin
            check_eq("row_start", row_start, 1);
            check_eq("dst_row", dst_row, r);
            check_eq("src_row", src_row, 2 * r);
            check_eq("row_mod", row_mod, mod);
            check_eq("row_asel", row_addrsel, asel);
            check_eq("no_ack_launch", pool_ack, 0);
            row_done = launch_done;
            step();
            row_done = 1'b0;
            if (r == abort_row) begin
                rstn = 1'b0;
                #1;
                drop_model = 0;
                check_all_zero("abort");
                repeat (3) begin
                    step();
                    check_eq("abort_no_ack", pool_ack, 0);
                end
                rstn = 1'b1;
                step();
                return;
            end
            d = $urandom_range(drop_wait ? 1 : 0, 3);
            repeat (d) begin
                check_eq("wait_no_start", row_start, 0);
                check_eq("wait_dst_hold", dst_row, r);
                pool_req = drop_wait;
                pool_height = 9'($urandom);
                if (drop_wait) drop_model++;
                step();
                pool_req = 1'b0;
            end
            check_eq("wait_busy", busy, 1);
            check_eq("wait_no_ack", pool_ack, 0);
            check_eq("wait_no_start2", row_start, 0);
            row_done = 1'b1;
            step();
            row_done = 1'b0;
        end
        check_eq("ack", pool_ack, 1);
        check_eq("ack_busy", busy, 1);
        check_eq("ack_no_start", row_start, 0);
        pool_req = drop_ack;
        if (drop_ack) drop_model++;
        step();
        pool_req = 1'b0;
        check_eq("ack_one_cycle", pool_ack, 0);
        check_eq("idle_after", busy, 0);
        check_eq("drop_cnt", drop_cnt, sat_drops());
        check_eq("err_clear", err, 0);
        // A stray done in IDLE must not start anything.
        row_done = 1'b1;
        step();
        row_done = 1'b0;
        check_eq("idle_done_ignored", busy, 0);
        check_eq("idle_done_no_start", row_start, 0);
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("reset");
        rstn = 1'b1;
        step();

        run_task(8, POOL_MOD_AVG, 3'd5, 1'b0, 1'b0, 1'b0, -1);
        run_task(7, POOL_MOD_MAX, 3'd2, 1'b0, 1'b0, 1'b0, -1);
        run_task(1, POOL_MOD_AVG, 3'd1, 1'b0, 1'b0, 1'b0, -1);
        run_task(0, POOL_MOD_MAX, 3'd6, 1'b0, 1'b0, 1'b0, -1);
        run_task(6, POOL_MOD_AVG, 3'd3, 1'b1, 1'b1, 1'b0, -1);
        run_task(4, POOL_MOD_MAX, 3'd7, 1'b0, 1'b0, 1'b1, -1);
        run_task(8, POOL_MOD_MAX, 3'd4, 1'b0, 1'b0, 1'b0, 2);
        run_task(4, POOL_MOD_AVG, 3'd1, 1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            run_task($urandom_range(0, 24), ($urandom_range(0, 1) != 0) ? POOL_MOD_AVG
                     : POOL_MOD_MAX, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        // Long task with drops on every row drives the drop counter into saturation.
        run_task(511, POOL_MOD_AVG, 3'd0, 1'b1, 1'b1, 1'b0, -1);
        check_eq("drop_saturated", drop_cnt, 255);

`ifdef POOL_TIMEOUT_EN
        begin
            int cnt;
            pool_req = 1'b1;
            pool_height = 9'd2;
            step();
            pool_req = 1'b0;
            check_eq("to_start", row_start, 1);
            step();
            cnt = 0;
            while (pool_ack !== 1'b1 && cnt < 40) begin
                step();
                cnt++;
            end
            check_eq("to_ack_delay", cnt, 16);
            check_eq("to_err", err, 1);
            step();
            check_eq("to_err_sticky", err, 1);
            rstn = 1'b0;
            step();
            rstn = 1'b1;
            drop_model = 0;
            step();
            pool_req = 1'b1;
            step();
            pool_req = 1'b0;
            check_eq("to_start2", row_start, 1);
            step();
            repeat (15) step();
            row_done = 1'b1;
            step();
            row_done = 1'b0;
            check_eq("to_race_ack", pool_ack, 1);
            check_eq("to_race_err", err, 0);
            step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
